// File: rtl/ipml_sync_prefetch_fifo_v2_0_if.sv
// ---------------------------------------------------------------------------
// ipml_sync_prefetch_fifo_v2_0_if
//   Bundles the write side, read side and status signals of the prefetch FIFO.
//   The producer/consumer side uses the master modport, the FIFO uses slave.
// Signals
//   wr_data, wr_en   write word and write request (master -> slave)
//   wr_vld           write ready; a write is taken when wr_en & wr_vld
//   rd_data, rd_vld  head word and its valid flag (slave -> master)
//   rd_en            pop request; a pop happens when rd_en & rd_vld
//   level            words held in the FIFO
//   almost_full      level at or above the almost-full threshold
//   almost_empty     level at or below the almost-empty threshold
//   overflow         one-cycle pulse after a write was refused
//   underflow        one-cycle pulse after a read was refused
// ---------------------------------------------------------------------------
interface ipml_sync_prefetch_fifo_v2_0_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WIDTH = 10
);
   logic [DATA_WIDTH-1:0]  wr_data;
   logic                   wr_en;
   logic                   wr_vld;
   logic [DATA_WIDTH-1:0]  rd_data;
   logic                   rd_en;
   logic                   rd_vld;
   logic [DEPTH_WIDTH:0]   level;
   logic                   almost_full;
   logic                   almost_empty;
   logic                   overflow;
   logic                   underflow;

   modport master (
      output wr_data, wr_en, rd_en,
      input  wr_vld, rd_data, rd_vld, level,
             almost_full, almost_empty, overflow, underflow
   );

   modport slave (
      input  wr_data, wr_en, rd_en,
      output wr_vld, rd_data, rd_vld, level,
             almost_full, almost_empty, overflow, underflow
   );
endinterface

// File: rtl/ipml_sync_prefetch_fifo_v2_0.sv
// ---------------------------------------------------------------------------
// ipml_sync_prefetch_fifo_v2_0
//   Single-clock first-word-fall-through FIFO. Words are stored in an inferred
//   RAM with a one-cycle registered read; a small prefetch buffer in front of
//   the read port keeps the head word registered on rd_data so the consumer
//   sees one word per cycle without bubbles.
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   flush      synchronous clear of the contents (rd_data keeps its value)
//   fifo_bus   slave side of ipml_sync_prefetch_fifo_v2_0_if: write/read
//              handshakes, level, almost flags and overflow/underflow pulses
// ---------------------------------------------------------------------------
module ipml_sync_prefetch_fifo_v2_0 #(
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH_WIDTH    = 10,
   parameter int PREFETCH_DEPTH = 2,
   parameter int AFULL_TH       = 1020,
   parameter int AEMPTY_TH      = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   ipml_sync_prefetch_fifo_v2_0_if.slave fifo_bus
);

   localparam int                   RAM_WORDS = 2 ** DEPTH_WIDTH;
   localparam logic [DEPTH_WIDTH:0] RAM_FULL  = (DEPTH_WIDTH + 1)'(RAM_WORDS);
   localparam logic [DEPTH_WIDTH:0] AFULL_LV  = (DEPTH_WIDTH + 1)'(AFULL_TH);
   localparam logic [DEPTH_WIDTH:0] AEMPTY_LV = (DEPTH_WIDTH + 1)'(AEMPTY_TH);
   localparam logic [2:0]           PF_MAX    = 3'(PREFETCH_DEPTH);

   logic [DATA_WIDTH-1:0]  mem [RAM_WORDS];
   logic [DATA_WIDTH-1:0]  ram_q;
   logic [DEPTH_WIDTH-1:0] wr_ptr;
   logic [DEPTH_WIDTH-1:0] rd_ptr;
   logic [DEPTH_WIDTH:0]   ram_cnt;
   logic [DEPTH_WIDTH:0]   level_q;
   logic                   in_flight;
   logic [2:0]             pf_cnt;
   logic [DATA_WIDTH-1:0]  pf_buf [PREFETCH_DEPTH];
   logic                   rd_vld_q;
   logic                   afull_q;
   logic                   aempty_q;
   logic                   overflow_q;
   logic                   underflow_q;

   logic                   clear;
   logic                   wr_vld;
   logic                   push;
   logic                   pop;
   logic                   issue;
   logic [2:0]             pf_after;
   logic [2:0]             pf_cnt_nxt;
   logic [DEPTH_WIDTH:0]   level_nxt;
   logic [DEPTH_WIDTH:0]   ram_cnt_nxt;
   logic [DATA_WIDTH-1:0]  pf_nxt [PREFETCH_DEPTH];
   int                     ins_idx;

   // Handshake qualification. Reset and flush override any request in the
   // same cycle, so nothing is written, popped or issued while clearing.
   // wr_vld only looks at the RAM body: the prefetch slots are refilled from
   // the RAM, so once the RAM is full every slot is already occupied.
   always_comb begin
      clear      = rst | flush;
      wr_vld     = (ram_cnt < RAM_FULL);
      push       = fifo_bus.wr_en & wr_vld & ~clear;
      pop        = fifo_bus.rd_en & rd_vld_q & ~clear;
      // Slots that will be taken after this edge by buffered plus in-flight
      // words; a new RAM read is launched only when one is still free.
      pf_after   = pf_cnt + {2'b00, in_flight} - {2'b00, pop};
      issue      = (ram_cnt != '0) & (pf_after < PF_MAX) & ~clear;
      pf_cnt_nxt = pf_cnt - {2'b00, pop} + {2'b00, in_flight};
      level_nxt  = level_q + {{DEPTH_WIDTH{1'b0}}, push} - {{DEPTH_WIDTH{1'b0}}, pop};
      ram_cnt_nxt = ram_cnt + {{DEPTH_WIDTH{1'b0}}, push} - {{DEPTH_WIDTH{1'b0}}, issue};
   end

   // Prefetch buffer next value. Entry 0 is always the head, so a pop shifts
   // the valid entries down by one; the returning RAM word lands in the first
   // free slot after the shift. Stale entries are left untouched so rd_data
   // keeps its last value when the buffer runs empty.
   always_comb begin
      ins_idx = int'(pf_cnt) - (pop ? 1 : 0);
      for (int i = 0; i < PREFETCH_DEPTH; i++) begin
         pf_nxt[i] = pf_buf[i];
      end
      if (pop) begin
         for (int i = 0; i < PREFETCH_DEPTH - 1; i++) begin
            if ((i + 1) < int'(pf_cnt)) begin
               pf_nxt[i] = pf_buf[i + 1];
            end
         end
      end
      if (in_flight) begin
         for (int i = 0; i < PREFETCH_DEPTH; i++) begin
            if (i == ins_idx) begin
               pf_nxt[i] = ram_q;
            end
         end
      end
   end

   // RAM body: write port plus one-cycle registered read port. Contents are
   // deliberately not reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= fifo_bus.wr_data;
      end
      if (issue) begin
         ram_q <= mem[rd_ptr];
      end
   end

   // Control state. Reset clears everything including the head register;
   // flush clears the same state but leaves the prefetch data (and therefore
   // rd_data) alone, and drops any RAM read that is still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         ram_cnt     <= '0;
         level_q     <= '0;
         in_flight   <= 1'b0;
         pf_cnt      <= '0;
         rd_vld_q    <= 1'b0;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         for (int i = 0; i < PREFETCH_DEPTH; i++) begin
            pf_buf[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         ram_cnt     <= '0;
         level_q     <= '0;
         in_flight   <= 1'b0;
         pf_cnt      <= '0;
         rd_vld_q    <= 1'b0;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         ram_cnt     <= ram_cnt_nxt;
         level_q     <= level_nxt;
         in_flight   <= issue;
         pf_cnt      <= pf_cnt_nxt;
         rd_vld_q    <= (pf_cnt_nxt != '0);
         afull_q     <= (level_nxt >= AFULL_LV);
         aempty_q    <= (level_nxt <= AEMPTY_LV);
         overflow_q  <= fifo_bus.wr_en & ~wr_vld;
         underflow_q <= fifo_bus.rd_en & ~rd_vld_q;
         for (int i = 0; i < PREFETCH_DEPTH; i++) begin
            pf_buf[i] <= pf_nxt[i];
         end
      end
   end

   assign fifo_bus.wr_vld       = wr_vld;
   assign fifo_bus.rd_data      = pf_buf[0];
   assign fifo_bus.rd_vld       = rd_vld_q;
   assign fifo_bus.level        = level_q;
   assign fifo_bus.almost_full  = afull_q;
   assign fifo_bus.almost_empty = aempty_q;
   assign fifo_bus.overflow     = overflow_q;
   assign fifo_bus.underflow    = underflow_q;

endmodule

// File: tb/tb_ipml_sync_prefetch_fifo_v2_0.sv
// ---------------------------------------------------------------------------
// tb_ipml_sync_prefetch_fifo_v2_0
//   Self-checking bench for the prefetch FIFO with a small configuration
//   (16-word RAM, 2 prefetch slots, capacity 18). The reference model is a
//   queue of words tagged with the edge at which they were accepted: the head
//   is visible two edges after acceptance, writes are taken while fewer than
//   CAPACITY words are held, and level is simply the queue size.
// ---------------------------------------------------------------------------
module tb_ipml_sync_prefetch_fifo_v2_0;

   localparam int DW  = 32;
   localparam int AW  = 4;
   localparam int PD  = 2;
   localparam int AF  = 14;
   localparam int AE  = 2;
   localparam int CAP = (2 ** AW) + PD;

   typedef struct {
      logic [DW-1:0] d;
      int            acc;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   ipml_sync_prefetch_fifo_v2_0_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) fifo_bus ();

   ipml_sync_prefetch_fifo_v2_0 #(
      .DATA_WIDTH    (DW),
      .DEPTH_WIDTH   (AW),
      .PREFETCH_DEPTH(PD),
      .AFULL_TH      (AF),
      .AEMPTY_TH     (AE)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .fifo_bus(fifo_bus)
   );

   always #5 clk = ~clk;

   ent_t          q[$];
   int            cyc = 0;
   logic [DW-1:0] last_data = '0;
   logic          exp_ovf = 1'b0;
   logic          exp_unf = 1'b0;
   int            checks = 0;
   int            errors = 0;
   int            max_level;

   function automatic bit modelRdVld();
      return (q.size() > 0) && (q[0].acc <= cyc - 2);
   endfunction

   function automatic bit modelWrVld();
      return q.size() < CAP;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      chk("rd_vld",       64'(fifo_bus.rd_vld),       64'(modelRdVld()));
      chk("wr_vld",       64'(fifo_bus.wr_vld),       64'(modelWrVld()));
      chk("level",        64'(fifo_bus.level),        64'(q.size()));
      chk("almost_full",  64'(fifo_bus.almost_full),  64'(q.size() >= AF));
      chk("almost_empty", 64'(fifo_bus.almost_empty), 64'(q.size() <= AE));
      chk("overflow",     64'(fifo_bus.overflow),     64'(exp_ovf));
      chk("underflow",    64'(fifo_bus.underflow),    64'(exp_unf));
      chk("rd_data",      64'(fifo_bus.rd_data),      64'(last_data));
   endtask

   // One clock cycle: drive inputs, advance the model at the edge using the
   // pre-edge model handshake state, then compare all outputs just after it.
   task automatic applyStimulus(input logic we, input logic [DW-1:0] wd,
                                input logic re, input logic fl, input logic rs);
      bit mw;
      bit mr;
      fifo_bus.wr_en   = we;
      fifo_bus.wr_data = wd;
      fifo_bus.rd_en   = re;
      flush            = fl;
      rst              = rs;
      mw = modelWrVld();
      mr = modelRdVld();
      @(posedge clk);
      cyc++;
      if (rs) begin
         q.delete();
         last_data = '0;
         exp_ovf   = 1'b0;
         exp_unf   = 1'b0;
      end else if (fl) begin
         q.delete();
         exp_ovf = 1'b0;
         exp_unf = 1'b0;
      end else begin
         exp_ovf = we & ~mw;
         exp_unf = re & ~mr;
         if (re && mr) void'(q.pop_front());
         if (we && mw) q.push_back('{d: wd, acc: cyc});
      end
      if (modelRdVld()) last_data = q[0].d;
      #1;
      checkOutput();
   endtask

   initial begin
      // Test 1: reset, single word latency and pop
      $display("[TB] test 1: reset and single word");
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("t1_reset_almost_empty", 64'(fifo_bus.almost_empty), 64'd1);
      applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("t1_not_yet_valid", 64'(fifo_bus.rd_vld), 64'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("t1_head_data", 64'(fifo_bus.rd_data), 64'h0000_0000_A5A5_0001);
      chk("t1_level", 64'(fifo_bus.level), 64'd1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t1_after_pop_level", 64'(fifo_bus.level), 64'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Test 2: overfill with 20 writes, then drain plus one extra read
      $display("[TB] test 2: fill to capacity and drain");
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      chk("t2_level_full", 64'(fifo_bus.level), 64'd18);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 19; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Test 3: streaming with rd_en held high
      $display("[TB] test 3: streaming throughput");
      max_level = 0;
      for (int i = 1; i <= 100; i++) begin
         applyStimulus(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
         if (int'(fifo_bus.level) > max_level) max_level = int'(fifo_bus.level);
      end
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t3_max_level_le_3", 64'(max_level <= 3), 64'd1);

      // Test 4: almost_full / almost_empty thresholds in both directions
      $display("[TB] test 4: threshold flags");
      for (int i = 0; i < 15; i++) applyStimulus(1'b1, DW'(32'h400 + i), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(32'h500 + i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Test 5: flush with concurrent requests, then a fresh word
      $display("[TB] test 5: flush");
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, DW'(32'h600 + i), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
      chk("t5_level_after_flush", 64'(fifo_bus.level), 64'd0);
      applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("t5_first_word", 64'(fifo_bus.rd_data), 64'h55);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Test 6: random traffic with occasional flush and reset
      $display("[TB] test 6: random traffic");
      for (int i = 0; i < 10000; i++) begin
         int  wp;
         logic we, re, fl, rs;
         wp = ((i / 500) % 2 == 0) ? 75 : 35;
         we = ($urandom_range(0, 99) < wp);
         re = ($urandom_range(0, 99) < (110 - wp));
         fl = ($urandom_range(0, 199) == 0);
         rs = ($urandom_range(0, 499) == 0);
         applyStimulus(we, DW'($urandom), re, fl, rs);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
